// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter with push FIFO and optional CTS flow control.
//
// Bytes pushed on the valid/ready interface are queued in an internal FIFO and
// serialised LSB-first on uart_txd: one start bit (0), eight data bits, one
// stop bit (1). Each bit lasts baudrate_div+1 clk cycles; the divider is
// captured when a frame starts, so edits made mid-frame apply from the next
// frame on. A new frame is started only while CTS (active low, synchronised)
// says the far end is ready; a frame already on the wire always completes.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset (clears all state)
//   baudrate_div  bit period minus one, in clk cycles
//   tx_data       byte to enqueue
//   tx_valid      push request
//   tx_ready      FIFO not full; a push happens when tx_valid && tx_ready
//   uart_cts_n    clear-to-send from the far end, active low, asynchronous
//   uart_txd      serial output, idle high
//   tx_busy       a frame is in progress (FSM not IDLE)
//   fifo_level    current FIFO occupancy, 0..2**FIFO_AW
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        baudrate_div,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic               uart_cts_n,
  output logic               uart_txd,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int                 DEPTH      = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   LEVEL_ZERO = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // CTS synchroniser
  // ---------------------------------------------------------------------------
  logic cts_meta_q;
  logic cts_sync_q;
  logic cts_ok_s;

  // Two-flop synchroniser; resets to "not clear" so nothing leaves before the
  // real pin state has been observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= uart_cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok_s = ~cts_sync_q;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_d;
  logic [FIFO_AW:0]   level_q;
  logic [FIFO_AW:0]   level_d;
  logic               ready_q;
  logic               push_s;
  logic               pop_s;
  logic [7:0]         head_s;

  assign push_s = tx_valid && ready_q;
  assign head_s = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= LEVEL_ZERO;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      // Ready is derived from the next level so it is exact every cycle; a
      // full FIFO therefore holds ready low even in a cycle that pops.
      ready_q  <= (level_d != LEVEL_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        txd_q;
  logic        txd_d;
  logic        busy_q;
  logic        start_ok_s;

  assign start_ok_s = (level_q != LEVEL_ZERO) && cts_ok_s;

  // Next-state, counters, FIFO pop and line level for the transmit FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
    txd_d     = 1'b1;

    // Line level follows the current state; it is registered, so the pin
    // trails the state by one cycle but every level lasts a full bit period.
    case (state_q)
      ST_IDLE:  txd_d = 1'b1;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          div_d   = baudrate_div;
          cnt_d   = baudrate_div;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = div_q;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next start bit when possible so
          // consecutive frames leave no idle gap on the line.
          if (start_ok_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            div_d   = baudrate_div;
            cnt_d   = baudrate_div;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, timing counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      div_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign tx_ready   = ready_q;
  assign fifo_level = level_q;

endmodule
